// File: rtl/mem_queue_if.sv
// Bus bundle for mem_queue: dispatch, address-generation writeback, ROB head,
// data-cache request/response and CDB broadcast. The queue uses the slave
// modport; the surrounding pipeline (or a bench) uses the master modport.
interface mem_queue_if #(
  parameter int unsigned ROB_IDX_W      = 5,
  parameter int unsigned PHYS_REG_W     = 6,
  parameter int unsigned MEM_ADDR_WIDTH = 3
) ();

  logic                      flush;

  logic                      dispatch_valid;
  logic                      dispatch_is_store;
  logic [2:0]                dispatch_funct3;
  logic [ROB_IDX_W-1:0]      dispatch_rob_idx;
  logic [PHYS_REG_W-1:0]     dispatch_pd;
  logic [MEM_ADDR_WIDTH-1:0] dispatch_mem_idx;
  logic                      full;

  logic                      addr_valid;
  logic [31:0]               mem_addr;
  logic [MEM_ADDR_WIDTH-1:0] mem_idx_in;
  logic [31:0]               store_wdata;

  logic [ROB_IDX_W-1:0]      rob_head_idx;

  logic [31:0]               dmem_addr;
  logic [3:0]                dmem_rmask;
  logic [3:0]                dmem_wmask;
  logic [31:0]               dmem_wdata;
  logic [31:0]               dmem_rdata;
  logic                      dmem_resp;

  logic                      cdb_valid;
  logic [ROB_IDX_W-1:0]      cdb_rob_idx;
  logic [PHYS_REG_W-1:0]     cdb_pd;
  logic [31:0]               cdb_rd_v;

  modport master (
    output flush,
    output dispatch_valid, dispatch_is_store, dispatch_funct3, dispatch_rob_idx, dispatch_pd,
    input  dispatch_mem_idx, full,
    output addr_valid, mem_addr, mem_idx_in, store_wdata,
    output rob_head_idx,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp,
    input  cdb_valid, cdb_rob_idx, cdb_pd, cdb_rd_v
  );

  modport slave (
    input  flush,
    input  dispatch_valid, dispatch_is_store, dispatch_funct3, dispatch_rob_idx, dispatch_pd,
    output dispatch_mem_idx, full,
    input  addr_valid, mem_addr, mem_idx_in, store_wdata,
    input  rob_head_idx,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp,
    output cdb_valid, cdb_rob_idx, cdb_pd, cdb_rd_v
  );

endinterface

// File: rtl/mem_queue.sv
// In-order load/store queue between address generation and the data cache.
// Entries are allocated at dispatch, completed by address writeback, and
// issued strictly from the head; results leave on a registered CDB port.
// MEM_ADDR_WIDTH mirrors the rv32i_types queue index width (default 3).
// Optional macro MEM_QUEUE_PERF_EN adds load/store/stall performance counters.
module mem_queue #(
  parameter int unsigned ROB_IDX_W      = 5,
  parameter int unsigned PHYS_REG_W     = 6,
  parameter int unsigned MEM_ADDR_WIDTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  mem_queue_if.slave  bus_io
`ifdef MEM_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_load_cnt_o,
  output logic [31:0] perf_store_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  localparam int unsigned Depth = 1 << MEM_ADDR_WIDTH;

  typedef logic [MEM_ADDR_WIDTH-1:0] idx_t;
  typedef logic [MEM_ADDR_WIDTH:0]   ptr_t;

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  // Control state
  state_e           state_q, state_d;
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] addr_rdy_q, addr_rdy_d;

  // Entry payload
  logic                  is_store_q [Depth];
  logic [2:0]            funct3_q   [Depth];
  logic [ROB_IDX_W-1:0]  rob_q      [Depth];
  logic [PHYS_REG_W-1:0] pd_q       [Depth];
  logic [31:0]           addr_q     [Depth];
  logic [31:0]           wdata_q    [Depth];

  // Data-cache request registers
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_rmask_q, dmem_rmask_d;
  logic [3:0]  dmem_wmask_q, dmem_wmask_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;

  // CDB registers
  logic                  cdb_valid_q, cdb_valid_d;
  logic [ROB_IDX_W-1:0]  cdb_rob_q, cdb_rob_d;
  logic [PHYS_REG_W-1:0] cdb_pd_q, cdb_pd_d;
  logic [31:0]           cdb_rd_q, cdb_rd_d;

  idx_t                  head_idx, tail_idx;
  logic                  is_full;
  logic                  do_dispatch, do_addr, complete;
  logic                  hd_valid, hd_rdy, hd_store, hd_rob_match, eligible;
  logic [2:0]            hd_funct3;
  logic [1:0]            hd_off;
  logic [31:0]           hd_addr, hd_wdata;
  logic [ROB_IDX_W-1:0]  hd_rob;
  logic [PHYS_REG_W-1:0] hd_pd;
  logic [3:0]            base_mask, req_mask;
  logic [31:0]           req_wdata, rd_shifted, load_val;

  // Head entry decode and queue-level qualifiers
  always_comb begin
    head_idx     = head_q[MEM_ADDR_WIDTH-1:0];
    tail_idx     = tail_q[MEM_ADDR_WIDTH-1:0];
    is_full      = (head_idx == tail_idx) && (head_q[MEM_ADDR_WIDTH] != tail_q[MEM_ADDR_WIDTH]);
    hd_valid     = valid_q[head_idx];
    hd_rdy       = addr_rdy_q[head_idx];
    hd_store     = is_store_q[head_idx];
    hd_funct3    = funct3_q[head_idx];
    hd_rob       = rob_q[head_idx];
    hd_pd        = pd_q[head_idx];
    hd_addr      = addr_q[head_idx];
    hd_wdata     = wdata_q[head_idx];
    hd_off       = hd_addr[1:0];
    hd_rob_match = (bus_io.rob_head_idx == hd_rob);
    // Stores must wait until they are the oldest ROB entry; loads may go early.
    eligible     = hd_valid && hd_rdy && (!hd_store || hd_rob_match);
    do_dispatch  = bus_io.dispatch_valid && !is_full && !bus_io.flush;
    do_addr      = bus_io.addr_valid && valid_q[bus_io.mem_idx_in] && !bus_io.flush;
  end

  // Request formation and load-result alignment for the head entry
  always_comb begin
    base_mask = 4'b1111;
    unique case (hd_funct3[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    req_mask   = base_mask << hd_off;
    req_wdata  = hd_wdata << {hd_off, 3'b000};
    rd_shifted = bus_io.dmem_rdata >> {hd_off, 3'b000};
    load_val   = rd_shifted;
    unique case (hd_funct3)
      3'b000:  load_val = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_val = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  load_val = {24'h0, rd_shifted[7:0]};
      3'b101:  load_val = {16'h0, rd_shifted[15:0]};
      default: load_val = rd_shifted;
    endcase
  end

  // Issue FSM next-state, request registers and CDB result capture
  always_comb begin
    state_d      = state_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_rmask_d = dmem_rmask_q;
    dmem_wmask_d = dmem_wmask_q;
    dmem_wdata_d = dmem_wdata_q;
    complete     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (eligible && !bus_io.flush) begin
          dmem_addr_d  = {hd_addr[31:2], 2'b00};
          dmem_rmask_d = hd_store ? 4'b0000 : req_mask;
          dmem_wmask_d = hd_store ? req_mask : 4'b0000;
          dmem_wdata_d = hd_store ? req_wdata : 32'h0;
          state_d      = StWait;
        end
      end
      StWait: begin
        if (bus_io.dmem_resp) begin
          dmem_rmask_d = 4'b0000;
          dmem_wmask_d = 4'b0000;
          // A response landing in the flush cycle belongs to a squashed op.
          complete     = !bus_io.flush;
          state_d      = StIdle;
        end else if (bus_io.flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Keep the request up until the cache finishes, then drop the result.
        if (bus_io.dmem_resp) begin
          dmem_rmask_d = 4'b0000;
          dmem_wmask_d = 4'b0000;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    cdb_valid_d = complete;
    cdb_rob_d   = complete ? hd_rob : '0;
    cdb_pd_d    = (complete && !hd_store) ? hd_pd : '0;
    cdb_rd_d    = (complete && !hd_store) ? load_val : 32'h0;
  end

  // Pointer and per-entry status next-state
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    valid_d    = valid_q;
    addr_rdy_d = addr_rdy_q;
    if (bus_io.flush) begin
      head_d     = '0;
      tail_d     = '0;
      valid_d    = '0;
      addr_rdy_d = '0;
    end else begin
      if (do_addr) begin
        addr_rdy_d[bus_io.mem_idx_in] = 1'b1;
      end
      if (complete) begin
        valid_d[head_idx]    = 1'b0;
        addr_rdy_d[head_idx] = 1'b0;
        head_d               = head_q + ptr_t'(1);
      end
      if (do_dispatch) begin
        valid_d[tail_idx]    = 1'b1;
        addr_rdy_d[tail_idx] = 1'b0;
        tail_d               = tail_q + ptr_t'(1);
      end
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      head_q       <= '0;
      tail_q       <= '0;
      valid_q      <= '0;
      addr_rdy_q   <= '0;
      dmem_addr_q  <= 32'h0;
      dmem_rmask_q <= 4'b0000;
      dmem_wmask_q <= 4'b0000;
      dmem_wdata_q <= 32'h0;
      cdb_valid_q  <= 1'b0;
      cdb_rob_q    <= '0;
      cdb_pd_q     <= '0;
      cdb_rd_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      valid_q      <= valid_d;
      addr_rdy_q   <= addr_rdy_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_rmask_q <= dmem_rmask_d;
      dmem_wmask_q <= dmem_wmask_d;
      dmem_wdata_q <= dmem_wdata_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_q    <= cdb_rob_d;
      cdb_pd_q     <= cdb_pd_d;
      cdb_rd_q     <= cdb_rd_d;
    end
  end

  // Entry payload; qualified by valid bits so it needs no reset
  always_ff @(posedge clk) begin
    if (do_dispatch) begin
      is_store_q[tail_idx] <= bus_io.dispatch_is_store;
      funct3_q[tail_idx]   <= bus_io.dispatch_funct3;
      rob_q[tail_idx]      <= bus_io.dispatch_rob_idx;
      pd_q[tail_idx]       <= bus_io.dispatch_pd;
    end
    if (do_addr) begin
      addr_q[bus_io.mem_idx_in]  <= bus_io.mem_addr;
      wdata_q[bus_io.mem_idx_in] <= bus_io.store_wdata;
    end
  end

  assign bus_io.full             = is_full;
  assign bus_io.dispatch_mem_idx = tail_idx;
  assign bus_io.dmem_addr        = dmem_addr_q;
  assign bus_io.dmem_rmask       = dmem_rmask_q;
  assign bus_io.dmem_wmask       = dmem_wmask_q;
  assign bus_io.dmem_wdata       = dmem_wdata_q;
  assign bus_io.cdb_valid        = cdb_valid_q;
  assign bus_io.cdb_rob_idx      = cdb_rob_q;
  assign bus_io.cdb_pd           = cdb_pd_q;
  assign bus_io.cdb_rd_v         = cdb_rd_q;

`ifdef MEM_QUEUE_PERF_EN
  logic [31:0] perf_load_q, perf_store_q, perf_stall_q;
  logic        stall_now;

  assign stall_now = hd_valid && (!hd_rdy || (hd_store && !hd_rob_match));

  // Free-running event counters; only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_load_q  <= 32'h0;
      perf_store_q <= 32'h0;
      perf_stall_q <= 32'h0;
    end else begin
      if (complete && !hd_store) perf_load_q <= perf_load_q + 32'd1;
      if (complete && hd_store)  perf_store_q <= perf_store_q + 32'd1;
      if (stall_now)             perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_load_cnt_o  = perf_load_q;
  assign perf_store_cnt_o = perf_store_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_queue.sv
// Bench for mem_queue: directed scenarios followed by randomized traffic.
// Expected CDB broadcasts go into a scoreboard queue; a monitor pops them.
module tb_mem_queue;

  localparam int unsigned RW = 5;
  localparam int unsigned PW = 6;
  localparam int unsigned AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_queue_if #(.ROB_IDX_W(RW), .PHYS_REG_W(PW), .MEM_ADDR_WIDTH(AW)) bus ();

  mem_queue #(.ROB_IDX_W(RW), .PHYS_REG_W(PW), .MEM_ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [4:0]  rob;
    logic [5:0]  pd;
    logic [31:0] rdv;
  } cdb_t;

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [4:0]  rob;
    logic [5:0]  pd;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          done;
  } op_t;

  cdb_t exp_q[$];
  cdb_t mon_e;
  op_t  ops[1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Byte lanes touched: size bytes starting at the byte offset
  function automatic logic [3:0] exp_mask(input logic [2:0] f3, input logic [1:0] off);
    int m;
    m = ((1 << size_of(f3)) - 1) << off;
    return 4'(m & 15);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rdata >> (8 * int'(off)));
    h = 16'(rdata >> (8 * int'(off)));
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

  // CDB monitor: every broadcast must match the oldest expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.cdb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL cdb_unexpected: got rob %0d expected no broadcast", bus.cdb_rob_idx);
      end else begin
        mon_e = exp_q.pop_front();
        chk("cdb_rob", 32'(bus.cdb_rob_idx), 32'(mon_e.rob));
        chk("cdb_pd", 32'(bus.cdb_pd), 32'(mon_e.pd));
        chk("cdb_rd_v", bus.cdb_rd_v, mon_e.rdv);
      end
    end
  end

  task automatic dispatch(input bit st, input logic [2:0] f3, input logic [4:0] rob,
                          input logic [5:0] pd, input int exp_idx);
    chk("dispatch_idx", 32'(bus.dispatch_mem_idx), 32'(exp_idx));
    bus.dispatch_valid    = 1'b1;
    bus.dispatch_is_store = st;
    bus.dispatch_funct3   = f3;
    bus.dispatch_rob_idx  = rob;
    bus.dispatch_pd       = pd;
    @(negedge clk);
    bus.dispatch_valid = 1'b0;
  endtask

  task automatic agen(input int idx, input logic [31:0] addr, input logic [31:0] wdata);
    bus.addr_valid  = 1'b1;
    bus.mem_idx_in  = AW'(idx);
    bus.mem_addr    = addr;
    bus.store_wdata = wdata;
    @(negedge clk);
    bus.addr_valid = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((bus.dmem_rmask | bus.dmem_wmask) != 4'b0000) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL req_timeout: got no request expected one within 20 cycles");
    end
  endtask

  task automatic respond(input logic [31:0] rdata);
    bus.dmem_rdata = rdata;
    bus.dmem_resp  = 1'b1;
    @(negedge clk);
    bus.dmem_resp = 1'b0;
  endtask

  task automatic chk_no_req(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk(name, 32'(bus.dmem_rmask | bus.dmem_wmask), 32'h0);
      @(negedge clk);
    end
  endtask

  // One complete directed access; hold > 0 keeps a store off the ROB head first
  task automatic access(input bit st, input logic [2:0] f3, input logic [4:0] rob,
                        input logic [5:0] pd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [3:0] x_rmask,
                        input logic [3:0] x_wmask, input logic [31:0] x_wdata,
                        input logic [31:0] x_rdv, input int idx, input int hold);
    bit ok;
    bus.rob_head_idx = (hold > 0) ? rob - 5'd1 : rob;
    dispatch(st, f3, rob, pd, idx);
    agen(idx, addr, wdata);
    if (hold > 0) begin
      chk_no_req("store_gated", hold);
      bus.rob_head_idx = rob;
    end
    wait_req(ok);
    if (ok) begin
      chk("req_addr", bus.dmem_addr, {addr[31:2], 2'b00});
      chk("req_rmask", 32'(bus.dmem_rmask), 32'(x_rmask));
      chk("req_wmask", 32'(bus.dmem_wmask), 32'(x_wmask));
      if (st) chk("req_wdata", bus.dmem_wdata, x_wdata);
      exp_q.push_back('{rob: rob, pd: st ? 6'd0 : pd, rdv: x_rdv});
      respond(rdata);
      chk("mask_cleared", 32'(bus.dmem_rmask | bus.dmem_wmask), 32'h0);
    end
  endtask

  initial begin
    bit          ok, full_now, stim;
    int          hs, ts, old_ts, dly, n, sel;
    bit          req_seen;
    op_t         op;
    logic [31:0] rd, r;
    logic [1:0]  off;

    rst = 1'b1;
    bus.flush = 1'b0;
    bus.dispatch_valid = 1'b0;
    bus.dispatch_is_store = 1'b0;
    bus.dispatch_funct3 = 3'b0;
    bus.dispatch_rob_idx = '0;
    bus.dispatch_pd = '0;
    bus.addr_valid = 1'b0;
    bus.mem_addr = 32'h0;
    bus.mem_idx_in = '0;
    bus.store_wdata = 32'h0;
    bus.rob_head_idx = '0;
    bus.dmem_rdata = 32'h0;
    bus.dmem_resp = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_idx", 32'(bus.dispatch_mem_idx), 32'h0);
    chk("rst_rmask", 32'(bus.dmem_rmask), 32'h0);
    chk("rst_wmask", 32'(bus.dmem_wmask), 32'h0);
    chk("rst_cdb", 32'(bus.cdb_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // LW, LB, LBU, SH (store held off the ROB head for 10 cycles)
    access(1'b0, 3'b010, 5'd3, 6'd5, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF,
           4'b1111, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0, 0);
    access(1'b0, 3'b000, 5'd4, 6'd9, 32'h1000_0003, 32'h0, 32'h8012_3456,
           4'b1000, 4'b0000, 32'h0, 32'hFFFF_FF80, 1, 0);
    access(1'b0, 3'b100, 5'd5, 6'd10, 32'h1000_0003, 32'h0, 32'h8012_3456,
           4'b1000, 4'b0000, 32'h0, 32'h0000_0080, 2, 0);
    access(1'b1, 3'b001, 5'd7, 6'd11, 32'h1000_0002, 32'h0000_ABCD, 32'h1234_5678,
           4'b0000, 4'b1100, 32'hABCD_0000, 32'h0, 3, 10);

    // Flush while the head load is waiting on the cache
    bus.rob_head_idx = 5'd1;
    dispatch(1'b0, 3'b010, 5'd1, 6'd1, 4);
    dispatch(1'b0, 3'b010, 5'd2, 6'd2, 5);
    agen(4, 32'h1000_0008, 32'h0);
    wait_req(ok);
    bus.flush = 1'b1;
    bus.dispatch_valid = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.dispatch_valid = 1'b0;
    chk("flush_idx", 32'(bus.dispatch_mem_idx), 32'h0);
    chk("flush_full", 32'(bus.full), 32'h0);
    chk("drain_rmask", 32'(bus.dmem_rmask), 32'hF);
    repeat (3) @(negedge clk);
    chk("drain_hold", 32'(bus.dmem_rmask), 32'hF);
    respond(32'h5555_AAAA);
    chk_no_req("drain_done", 3);
    agen(5, 32'h1000_000C, 32'h0);
    chk_no_req("agen_invalid", 4);

    // Fill to full, overfill, then free one slot
    for (int i = 0; i < 8; i++) dispatch(1'b0, 3'b010, 5'(10 + i), 6'(i), i);
    chk("full_set", 32'(bus.full), 32'h1);
    dispatch(1'b0, 3'b010, 5'd30, 6'd30, 0);
    chk("overfill_idx", 32'(bus.dispatch_mem_idx), 32'h0);
    chk("overfill_full", 32'(bus.full), 32'h1);
    agen(0, 32'h1000_0020, 32'h0);
    wait_req(ok);
    exp_q.push_back('{rob: 5'd10, pd: 6'd0, rdv: 32'h0BAD_F00D});
    respond(32'h0BAD_F00D);
    chk("full_clear", 32'(bus.full), 32'h0);
    chk("wrap_idx", 32'(bus.dispatch_mem_idx), 32'h0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized traffic against a program-order model
    hs = 0;
    ts = 0;
    req_seen = 1'b0;
    dly = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stim = (cyc < 1200);
      if (!stim && hs == ts) break;
      full_now = ((ts - hs) == 8);
      chk("rnd_full", 32'(bus.full), 32'(full_now));
      chk("rnd_tail", 32'(bus.dispatch_mem_idx), 32'(ts % 8));
      if (!req_seen && (bus.dmem_rmask | bus.dmem_wmask) != 4'b0000) begin
        if (hs == ts) begin
          vectors++;
          errors++;
          $display("FAIL rnd_spurious_req: got mask %b expected none", bus.dmem_rmask);
        end else begin
          op = ops[hs];
          off = op.addr[1:0];
          chk("rnd_addr", bus.dmem_addr, {op.addr[31:2], 2'b00});
          chk("rnd_rmask", 32'(bus.dmem_rmask), op.st ? 32'h0 : 32'(exp_mask(op.f3, off)));
          chk("rnd_wmask", 32'(bus.dmem_wmask), op.st ? 32'(exp_mask(op.f3, off)) : 32'h0);
          if (op.st) begin
            chk("rnd_wdata", bus.dmem_wdata, op.wdata << (8 * int'(off)));
            chk("rnd_st_at_head", 32'(bus.rob_head_idx), 32'(op.rob));
          end
          req_seen = 1'b1;
          dly = $urandom_range(0, 3);
        end
      end
      bus.dmem_resp = 1'b0;
      bus.dispatch_valid = 1'b0;
      bus.addr_valid = 1'b0;
      old_ts = ts;
      if (req_seen) begin
        if (dly == 0) begin
          rd = $urandom;
          op = ops[hs];
          bus.dmem_rdata = rd;
          bus.dmem_resp = 1'b1;
          exp_q.push_back('{rob: op.rob, pd: op.st ? 6'd0 : op.pd,
                            rdv: op.st ? 32'h0 : exp_load(op.f3, op.addr[1:0], rd)});
          hs++;
          req_seen = 1'b0;
        end else begin
          dly--;
        end
      end
      if (stim && $urandom_range(0, 1) == 1) begin
        op.st = ($urandom_range(0, 2) == 0);
        sel = op.st ? $urandom_range(0, 2) : $urandom_range(0, 4);
        case (sel)
          0: op.f3 = 3'b000;
          1: op.f3 = 3'b001;
          2: op.f3 = 3'b010;
          3: op.f3 = 3'b100;
          default: op.f3 = 3'b101;
        endcase
        op.rob = 5'(ts % 32);
        op.pd = 6'($urandom_range(1, 63));
        r = $urandom;
        case (size_of(op.f3))
          1: off = r[1:0];
          2: off = {r[1], 1'b0};
          default: off = 2'b00;
        endcase
        op.addr = {r[31:2], off};
        op.wdata = $urandom;
        op.done = 1'b0;
        bus.dispatch_valid = 1'b1;
        bus.dispatch_is_store = op.st;
        bus.dispatch_funct3 = op.f3;
        bus.dispatch_rob_idx = op.rob;
        bus.dispatch_pd = op.pd;
        if (!full_now) begin
          ops[ts] = op;
          ts++;
        end
      end
      n = old_ts - hs;
      if (n > 0 && $urandom_range(0, 2) != 0) begin
        for (int k = hs + int'($urandom_range(0, n - 1)); k < old_ts; k++) begin
          if (!ops[k].done) begin
            ops[k].done = 1'b1;
            bus.addr_valid = 1'b1;
            bus.mem_idx_in = AW'(k % 8);
            bus.mem_addr = ops[k].addr;
            bus.store_wdata = ops[k].wdata;
            break;
          end
        end
      end
      if (hs < ts) begin
        bus.rob_head_idx = ($urandom_range(0, 3) != 0) ? ops[hs].rob : ops[hs].rob + 5'd1;
      end else begin
        bus.rob_head_idx = 5'($urandom);
      end
      @(negedge clk);
    end
    if (hs != ts) begin
      vectors++;
      errors++;
      $display("FAIL rnd_drain: got %0d ops outstanding expected 0", ts - hs);
    end
    bus.dmem_resp = 1'b0;
    bus.dispatch_valid = 1'b0;
    bus.addr_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_queue.md
Name: mem_queue

Overview:
- In-order load/store queue directly downstream of the memory functional unit's address-generation stage.
- Dispatch allocates entries in program order and returns the entry index that travels with the instruction to address generation.
- Computed address and store data write back into the entry by index.
- Head entry issues to the data cache; load data and store completions broadcast on a registered CDB port.

Parameters:
- ROB_IDX_W, 5, width of ROB index tag.
- PHYS_REG_W, 6, width of physical destination register tag.
- Queue index width is MEM_ADDR_WIDTH from rv32i_types; DEPTH = 2**MEM_ADDR_WIDTH (8 when MEM_ADDR_WIDTH=3).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush (mispredict).
- dispatch_valid  in  1  allocate entry.
- dispatch_is_store  in  1  1=store, 0=load.
- dispatch_funct3  in  3  RV32I load/store funct3.
- dispatch_rob_idx  in  ROB_IDX_W  ROB tag.
- dispatch_pd  in  PHYS_REG_W  load destination physical register.
- dispatch_mem_idx  out  MEM_ADDR_WIDTH  index of next allocated entry (tail).
- full  out  1  no free entry.
- addr_valid  in  1  address-generation result valid.
- mem_addr  in  32  effective address.
- mem_idx_in  in  MEM_ADDR_WIDTH  entry to update.
- store_wdata  in  32  store source data.
- rob_head_idx  in  ROB_IDX_W  ROB head tag.
- dmem_addr  out  32  word-aligned address.
- dmem_rmask  out  4  read byte mask.
- dmem_wmask  out  4  write byte mask.
- dmem_wdata  out  32  lane-aligned write data.
- dmem_rdata  in  32  read data.
- dmem_resp  in  1  request complete.
- cdb_valid  out  1  broadcast pulse.
- cdb_rob_idx  out  ROB_IDX_W  completing ROB tag.
- cdb_pd  out  PHYS_REG_W  destination register (0 for stores).
- cdb_rd_v  out  32  load result (0 for stores).

Behaviour:
- Reset: all outputs 0. Pointers 0, all entries invalid, FSM IDLE.
- Storage:
  - Circular buffer; head/tail carry one extra wrap bit.
  - full = (head index == tail index) and (wrap bits differ), from current state.
  - dispatch_mem_idx = tail index.
- Dispatch:
  - dispatch_valid && !full allocates at tail with addr_rdy=0, and tail increments.
  - Dispatch while full is ignored.
- Address write:
  - addr_valid writes addr, wdata and sets addr_rdy on entry mem_idx_in.
  - Writes to an invalid entry are ignored.
  - Address write and dispatch in the same cycle to different entries are both honoured.
- Issue eligibility (head entry):
  - Head valid and addr_rdy.
  - For a store, additionally rob_head_idx == entry rob_idx.
  - Evaluated on registered state, so an entry written this cycle is eligible next cycle at the earliest.
- FSM:
  - IDLE: if eligible, register request outputs → WAIT (request visible the cycle after eligibility).
  - WAIT: request outputs held stable. On dmem_resp: clear masks, capture result, pop head, pulse cdb_valid the following cycle → IDLE.
  - DRAIN: entered from WAIT on flush. Masks held until dmem_resp. Response discarded, no cdb_valid → IDLE.
- Request formation:
  - dmem_addr = {addr[31:2],2'b00}.
  - Base mask: B=0001, H=0011, W=1111, shifted left by addr[1:0], truncated to 4 bits.
  - Misaligned accesses are unsupported; no trap raised.
  - Loads drive rmask and wmask=0. Stores drive wmask, rmask=0, and dmem_wdata = wdata << (8*addr[1:0]).
- Load result:
  - Data = dmem_rdata >> (8*addr[1:0]).
  - funct3 000 sign-extend byte; 001 sign-extend half; 010 word; 100 zero-extend byte; 101 zero-extend half.
- Store completion: cdb_valid with cdb_pd=0, cdb_rd_v=0.
- Flush:
  - Invalidates all entries; head=tail=0 next cycle.
  - From WAIT → DRAIN. From IDLE stays IDLE. A pending cdb_valid pulse is suppressed.
  - Dispatch in the flush cycle is ignored.
- Reset mid-request: immediate IDLE, outputs 0; the dcache side is reset by the same rst.

Optional Feature:
- Macro MEM_QUEUE_PERF_EN.
- When defined, adds outputs:
  - perf_load_cnt[31:0]: increments on each load response not discarded.
  - perf_store_cnt[31:0]: increments on each store response.
  - perf_stall_cnt[31:0]: increments each cycle head is valid with addr_rdy=0, or is a store not at ROB head.
  - All counters cleared by rst only; they wrap.
- When undefined, these ports and counters are absent; functional behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles → full=0, dispatch_mem_idx=0, masks 0, cdb_valid=0.
- LW: dispatch load rob=3 pd=5; addr_valid mem_addr=0x10000004 → next cycle dmem_addr=0x10000004, rmask=1111. dmem_resp with rdata=0xDEADBEEF → cdb_valid one cycle, rob=3, pd=5, rd_v=0xDEADBEEF.
- LB/LBU at 0x10000003, rdata=0x80123456 → rmask=1000. LB rd_v=0xFFFFFF80; LBU rd_v=0x00000080.
- SH at 0x10000002, wdata=0x0000ABCD, entry rob=7:
  - rob_head_idx=6 → no request for 10 cycles.
  - rob_head_idx=7 → wmask=1100, wdata=0xABCD0000, rmask=0.
  - Response → cdb_valid with pd=0.
- Full/wrap: 8 dispatches → full=1; 9th ignored (tail unchanged). Complete one → full=0, dispatch_mem_idx=0 (wrapped).
- Flush during WAIT → no cdb_valid, mask held until dmem_resp, then IDLE with head=tail=0. Next dispatch receives index 0.
